wb_pipe_reg: RTL and testbench

WB_PIPE_REG -- requirements
Module: wb_pipe_reg

---
 rtl/wb_pkg.sv | 22 ++
 rtl/load_extend.sv | 43 ++++
 rtl/wb_pipe_reg.sv | 136 +++++++++++++
 tb/tb_wb_pipe_reg.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback pipeline register.
// Result-source encoding, load funct3 codes and W-stage FSM states.
package wb_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_src_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/load_extend.sv
// Load data aligner/extender: picks byte/half by address offset and
// sign- or zero-extends by funct3. Ports: rdata, funct3, offset -> data.
module load_extend
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (offset)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
      default: b = rdata[7:0];
    endcase
  end

  // halfword select ignores offset[0]
  assign h = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    unique case (funct3)
      F3_LB:   data = {{(XLEN-8){b[7]}}, b};
      F3_LH:   data = {{(XLEN-16){h[15]}}, h};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, h};
      F3_LW:   data = rdata;
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_pipe_reg.sv
// M->W pipeline register with load-wait FSM and stall counter.
// Ports: clk/nrst, stall_i/flush_i, M-stage bundle + dmem response in;
// W-stage bundle, m_ready_o, mem_wait_o, load_stall_cnt_o out.
// Optional WB_LOAD_EXT_EN: funct3-based load extension via load_extend.
module wb_pipe_reg
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  m_valid_i,
  output logic                  m_ready_o,
  input  logic [XLEN-1:0]       alu_result_m_i,
  input  logic [XLEN-1:0]       pc_plus4_m_i,
  input  logic [REG_ADDR_W-1:0] rd_m_i,
  input  logic                  regwrite_m_i,
  input  logic [1:0]            result_src_m_i,
  input  logic [2:0]            load_funct3_m_i,
  input  logic [XLEN-1:0]       dmem_rdata_i,
  input  logic                  dmem_rvalid_i,
  output logic                  w_valid_o,
  output logic [REG_ADDR_W-1:0] rd_w_o,
  output logic                  regwrite_w_o,
  output logic [XLEN-1:0]       result_w_o,
  output logic [XLEN-1:0]       alu_result_w_o,
  output logic [XLEN-1:0]       read_data_w_o,
  output logic [XLEN-1:0]       pc_plus4_w_o,
  output logic                  mem_wait_o,
  output logic [31:0]           load_stall_cnt_o
);

  wb_state_e       state;
  wb_state_e       state_nxt;
  logic            is_load;
  logic            ld_miss;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] res_nxt;

  assign is_load   = m_valid_i &&
                     (result_src_m_i == RES_MEM);
  assign m_ready_o = !stall_i &&
                     (!is_load || dmem_rvalid_i);
  // an advancing load whose data has not arrived
  assign ld_miss   = is_load && !dmem_rvalid_i &&
                     !stall_i && !flush_i;

`ifdef WB_LOAD_EXT_EN
  load_extend #(
    .XLEN(XLEN)
  ) u_load_extend (
    .rdata (dmem_rdata_i),
    .funct3(load_funct3_m_i),
    .offset(alu_result_m_i[1:0]),
    .data  (ld_data)
  );
`else
  logic unused_funct3;
  assign unused_funct3 = ^load_funct3_m_i;
  assign ld_data       = dmem_rdata_i;
`endif

  always_comb begin
    res_nxt = '0;
    unique case (result_src_m_i)
      RES_ALU: res_nxt = alu_result_m_i;
      RES_MEM: res_nxt = ld_data;
      RES_PC4: res_nxt = pc_plus4_m_i;
      default: res_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= ST_RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush_i) begin
      state_nxt = ST_RUN;
    end else if (!stall_i) begin
      unique case (state)
        ST_RUN:  if (ld_miss) state_nxt = ST_WAIT;
        ST_WAIT: if (dmem_rvalid_i) state_nxt = ST_RUN;
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    mem_wait_o = (state == ST_WAIT);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      w_valid_o      <= 1'b0;
      rd_w_o         <= '0;
      regwrite_w_o   <= 1'b0;
      result_w_o     <= '0;
      alu_result_w_o <= '0;
      read_data_w_o  <= '0;
      pc_plus4_w_o   <= '0;
    end else if (flush_i) begin
      w_valid_o    <= 1'b0;
      regwrite_w_o <= 1'b0;
    end else if (!stall_i) begin
      if (m_ready_o) begin
        w_valid_o      <= m_valid_i;
        rd_w_o         <= rd_m_i;
        regwrite_w_o   <= m_valid_i && regwrite_m_i &&
                          (rd_m_i != '0);
        result_w_o     <= res_nxt;
        alu_result_w_o <= alu_result_m_i;
        pc_plus4_w_o   <= pc_plus4_m_i;
        // rdata only matters for a real load
        if (is_load) read_data_w_o <= ld_data;
      end else begin
        w_valid_o    <= 1'b0;
        regwrite_w_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      load_stall_cnt_o <= '0;
    end else if (ld_miss && (load_stall_cnt_o != '1)) begin
      load_stall_cnt_o <= load_stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Randomized + directed bench for wb_pipe_reg against a
// behavioural model of the W-stage register rules.
module tb_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        nrst;
  logic        stall_i, flush_i, m_valid_i, m_ready_o;
  logic [31:0] alu_result_m_i, pc_plus4_m_i, dmem_rdata_i;
  logic [4:0]  rd_m_i;
  logic        regwrite_m_i, dmem_rvalid_i;
  logic [1:0]  result_src_m_i;
  logic [2:0]  load_funct3_m_i;
  logic        w_valid_o, regwrite_w_o, mem_wait_o;
  logic [4:0]  rd_w_o;
  logic [31:0] result_w_o, alu_result_w_o;
  logic [31:0] read_data_w_o, pc_plus4_w_o;
  logic [31:0] load_stall_cnt_o;

  always #5 clk = ~clk;

  wb_pipe_reg #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .nrst(nrst),
    .stall_i(stall_i), .flush_i(flush_i),
    .m_valid_i(m_valid_i), .m_ready_o(m_ready_o),
    .alu_result_m_i(alu_result_m_i),
    .pc_plus4_m_i(pc_plus4_m_i),
    .rd_m_i(rd_m_i), .regwrite_m_i(regwrite_m_i),
    .result_src_m_i(result_src_m_i),
    .load_funct3_m_i(load_funct3_m_i),
    .dmem_rdata_i(dmem_rdata_i),
    .dmem_rvalid_i(dmem_rvalid_i),
    .w_valid_o(w_valid_o), .rd_w_o(rd_w_o),
    .regwrite_w_o(regwrite_w_o),
    .result_w_o(result_w_o),
    .alu_result_w_o(alu_result_w_o),
    .read_data_w_o(read_data_w_o),
    .pc_plus4_w_o(pc_plus4_w_o),
    .mem_wait_o(mem_wait_o),
    .load_stall_cnt_o(load_stall_cnt_o)
  );

  int errors = 0;
  int checks = 0;

  // model of the W-stage contents
  bit          e_valid, e_rw, e_wait;
  int unsigned e_rd;
  longint      e_res, e_alu, e_rdat, e_pc4, e_cnt;

  task automatic chk(string nm, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               nm, act, exp);
    end
  endtask

  function automatic longint load_val(longint d,
                                      int f3, int off);
    longint v;
`ifdef WB_LOAD_EXT_EN
    if (f3 == 0 || f3 == 4) begin
      v = (d >> (8 * off)) & 64'hFF;
      if (f3 == 0 && v >= 128) v = v | 64'hFFFF_FF00;
    end else if (f3 == 1 || f3 == 5) begin
      v = (d >> (16 * (off / 2))) & 64'hFFFF;
      if (f3 == 1 && v >= 32768) v = v | 64'hFFFF_0000;
    end else begin
      v = d;
    end
`else
    v = d;
`endif
    return v;
  endfunction

  function automatic bit is_ld();
    return m_valid_i && result_src_m_i == 2'd1;
  endfunction

  function automatic bit ready_exp();
    return !stall_i && (!is_ld() || dmem_rvalid_i);
  endfunction

  task automatic model_reset();
    e_valid = 0; e_rw = 0; e_wait = 0; e_rd = 0;
    e_res = 0; e_alu = 0; e_rdat = 0; e_pc4 = 0;
    e_cnt = 0;
  endtask

  task automatic model_edge();
    bit     ld, rdy;
    longint lv;
    ld  = is_ld();
    rdy = ready_exp();
    lv  = load_val(dmem_rdata_i, load_funct3_m_i,
                   alu_result_m_i[1:0]);
    if (ld && !dmem_rvalid_i && !stall_i && !flush_i
        && e_cnt < 64'hFFFF_FFFF)
      e_cnt++;
    if (flush_i) begin
      e_valid = 0; e_rw = 0; e_wait = 0;
    end else if (!stall_i) begin
      if (e_wait && dmem_rvalid_i) e_wait = 0;
      else if (!e_wait && ld && !dmem_rvalid_i) e_wait = 1;
      if (rdy) begin
        e_valid = m_valid_i;
        e_rd    = rd_m_i;
        e_rw    = m_valid_i && regwrite_m_i && rd_m_i != 0;
        e_alu   = alu_result_m_i;
        e_pc4   = pc_plus4_m_i;
        if (ld) e_rdat = lv;
        case (result_src_m_i)
          2'd0:    e_res = alu_result_m_i;
          2'd1:    e_res = lv;
          2'd2:    e_res = pc_plus4_m_i;
          default: e_res = 0;
        endcase
      end else begin
        e_valid = 0; e_rw = 0;
      end
    end
  endtask

  task automatic compare_all();
    chk("m_ready", m_ready_o, ready_exp());
    chk("w_valid", w_valid_o, e_valid);
    chk("rd_w", rd_w_o, e_rd);
    chk("regwrite_w", regwrite_w_o, e_rw);
    chk("result_w", result_w_o, e_res);
    chk("alu_w", alu_result_w_o, e_alu);
    chk("rdata_w", read_data_w_o, e_rdat);
    chk("pc4_w", pc_plus4_w_o, e_pc4);
    chk("mem_wait", mem_wait_o, e_wait);
    chk("stall_cnt", load_stall_cnt_o, e_cnt);
  endtask

  task automatic drv(bit mv, int src, int f3,
                     logic [31:0] alu, logic [31:0] pc4,
                     int rd, bit rw, logic [31:0] rdat,
                     bit rv, bit st, bit fl);
    m_valid_i       = mv;
    result_src_m_i  = src[1:0];
    load_funct3_m_i = f3[2:0];
    alu_result_m_i  = alu;
    pc_plus4_m_i    = pc4;
    rd_m_i          = rd[4:0];
    regwrite_m_i    = rw;
    dmem_rdata_i    = rdat;
    dmem_rvalid_i   = rv;
    stall_i         = st;
    flush_i         = fl;
    #1;
  endtask

  task automatic cyc();
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic chk_zero_outs(string tag);
    chk({tag, "_valid"}, w_valid_o, 0);
    chk({tag, "_rw"}, regwrite_w_o, 0);
    chk({tag, "_rd"}, rd_w_o, 0);
    chk({tag, "_res"}, result_w_o, 0);
    chk({tag, "_alu"}, alu_result_w_o, 0);
    chk({tag, "_rdat"}, read_data_w_o, 0);
    chk({tag, "_pc4"}, pc_plus4_w_o, 0);
    chk({tag, "_wait"}, mem_wait_o, 0);
    chk({tag, "_cnt"}, load_stall_cnt_o, 0);
  endtask

  longint exp_lb, exp_lbu;

  initial begin
    nrst = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk_zero_outs("reset");
    nrst = 1'b1;

    // ALU op into x5
    drv(1, 0, 0, 32'h1234, 32'h104, 5, 1, 0, 0, 0, 0);
    cyc();
    chk("alu_valid", w_valid_o, 1);
    chk("alu_rd", rd_w_o, 5);
    chk("alu_res", result_w_o, 32'h1234);
    chk("alu_rw", regwrite_w_o, 1);

    // LB / LBU at offset 3
`ifdef WB_LOAD_EXT_EN
    exp_lb  = 64'hFFFF_FF80;
    exp_lbu = 64'h0000_0080;
`else
    exp_lb  = 64'h80FF_FF7F;
    exp_lbu = 64'h80FF_FF7F;
`endif
    drv(1, 1, 0, 32'h203, 32'h108, 7, 1,
        32'h80FF_FF7F, 1, 0, 0);
    cyc();
    chk("lb_res", result_w_o, exp_lb);
    drv(1, 1, 4, 32'h203, 32'h10C, 7, 1,
        32'h80FF_FF7F, 1, 0, 0);
    cyc();
    chk("lbu_res", result_w_o, exp_lbu);

    // load waiting 3 cycles
    for (int i = 0; i < 3; i++) begin
      drv(1, 1, 2, 32'h100, 32'h110, 9, 1,
          32'hDEAD_BEEF, 0, 0, 0);
      chk("wait_ready", m_ready_o, 0);
      cyc();
      chk("wait_memw", mem_wait_o, 1);
      chk("wait_bubble", w_valid_o, 0);
    end
    drv(1, 1, 2, 32'h100, 32'h110, 9, 1,
        32'h1122_3344, 1, 0, 0);
    chk("ret_ready", m_ready_o, 1);
    cyc();
    chk("ret_valid", w_valid_o, 1);
    chk("ret_memw", mem_wait_o, 0);
    chk("ret_cnt", load_stall_cnt_o, 3);
    chk("ret_res", result_w_o, 32'h1122_3344);

    // write to x0 is suppressed
    drv(1, 0, 0, 32'hDEAD, 32'h114, 0, 1, 0, 0, 0, 0);
    cyc();
    chk("x0_valid", w_valid_o, 1);
    chk("x0_rw", regwrite_w_o, 0);

    // flush wins over stall
    drv(1, 0, 0, 32'h55, 32'h118, 3, 1, 0, 0, 0, 0);
    cyc();
    drv(1, 1, 0, 32'h66, 32'h11C, 4, 1, 0, 0, 1, 1);
    cyc();
    chk("fl_valid", w_valid_o, 0);
    chk("fl_rw", regwrite_w_o, 0);
    chk("fl_memw", mem_wait_o, 0);

    // async reset mid-WAIT
    drv(1, 1, 2, 32'h200, 32'h120, 6, 1, 0, 0, 0, 0);
    cyc();
    cyc();
    chk("pre_rst_memw", mem_wait_o, 1);
    #2;
    nrst = 1'b0;
    #1;
    chk_zero_outs("arst");
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    nrst = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drv($urandom_range(3) != 0, $urandom_range(3),
          $urandom_range(7), $urandom, $urandom,
          ($urandom_range(7) == 0) ? 0 : $urandom_range(31),
          $urandom_range(1), $urandom,
          $urandom_range(1),
          $urandom_range(7) == 0,
          $urandom_range(15) == 0);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
